// File: rtl/fifo_pkg.sv
// Shared types and helpers for the threshold FIFO.
package fifo_pkg;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    function automatic int unsigned cnt_w(input int unsigned dp);
        return 32'($clog2(dp + 1));
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DW x DP storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int unsigned DW = 8,
    parameter int unsigned DP = 24,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DP];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow and selectable registered or FWFT read.
module fifo_thresh
    import fifo_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DP    = 24,
    parameter int unsigned AF_TH = DP - 2,
    parameter int unsigned AE_TH = 2,
    parameter fifo_mode_e  MODE  = STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    input  logic                   clr_err,
    output logic [DW-1:0]          pop_data_o,
    output logic                   full_flag,
    output logic                   empty_flag,
    output logic                   almost_full_o,
    output logic                   almost_empty_o,
    output logic [cnt_w(DP)-1:0]   count_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int unsigned CW = cnt_w(DP);
    localparam int unsigned AW = (DP > 1) ? $clog2(DP) : 1;

    if (DP < 2) begin : g_bad_dp
        $error("fifo_thresh: DP must be at least 2");
    end
    if (AF_TH < 1 || AF_TH > DP - 1) begin : g_bad_af
        $error("fifo_thresh: AF_TH must lie in 1..DP-1");
    end
    if (AE_TH < 1 || AE_TH > DP - 1) begin : g_bad_ae
        $error("fifo_thresh: AE_TH must lie in 1..DP-1");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          udf_q;
    logic [DW-1:0] rd_data;
    logic          push_acc;
    logic          pop_acc;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DP - 1)) ? '0 : p + AW'(1);
    endfunction

    // Flags decode from the registered count only.
    assign full_flag      = (count_q == CW'(DP));
    assign empty_flag     = (count_q == '0);
    assign almost_full_o  = (count_q >= CW'(AF_TH));
    assign almost_empty_o = (count_q <= CW'(AE_TH));
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

    // A simultaneous pop frees the slot a push into a full FIFO needs.
    assign pop_acc  = pop && !empty_flag;
    assign push_acc = push && (!full_flag || pop_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_acc && !pop_acc) begin
                count_q <= count_q + CW'(1);
            end else if (!push_acc && pop_acc) begin
                count_q <= count_q - CW'(1);
            end
            // New errors take priority over a same-cycle clear.
            if (push && !push_acc) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (pop && !pop_acc) begin
                udf_q <= 1'b1;
            end else if (clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DW (DW),
        .DP (DP),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (push_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    if (MODE == STD) begin : g_std
        logic [DW-1:0] pd_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pd_q <= '0;
            end else if (pop_acc) begin
                pd_q <= rd_data;
            end
        end

        assign pop_data_o = pd_q;
    end else begin : g_fwft
        // Head word is shown only while valid so stale storage never leaks out.
        assign pop_data_o = empty_flag ? '0 : rd_data;
    end

endmodule

// File: tb/tb_fifo_thresh.sv
// Directed self-checking bench for fifo_thresh (STD and FWFT instances).
module tb_fifo_thresh;
    import fifo_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 24;
    localparam int unsigned CW = cnt_w(DP);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          s_push = 1'b0, s_pop = 1'b0, s_clr = 1'b0;
    logic [DW-1:0] s_push_data = '0;
    logic [DW-1:0] s_pop_data;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [CW-1:0] s_count;

    logic          f_push = 1'b0, f_pop = 1'b0, f_clr = 1'b0;
    logic [DW-1:0] f_push_data = '0;
    logic [DW-1:0] f_pop_data;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [CW-1:0] f_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_thresh #(.DW(DW), .DP(DP), .MODE(STD)) u_std (
        .clk(clk), .rst(rst), .push(s_push), .push_data(s_push_data),
        .pop(s_pop), .clr_err(s_clr), .pop_data_o(s_pop_data),
        .full_flag(s_full), .empty_flag(s_empty), .almost_full_o(s_af),
        .almost_empty_o(s_ae), .count_o(s_count), .overflow_o(s_ovf),
        .underflow_o(s_udf)
    );

    fifo_thresh #(.DW(DW), .DP(DP), .MODE(FWFT)) u_fwft (
        .clk(clk), .rst(rst), .push(f_push), .push_data(f_push_data),
        .pop(f_pop), .clr_err(f_clr), .pop_data_o(f_pop_data),
        .full_flag(f_full), .empty_flag(f_empty), .almost_full_o(f_af),
        .almost_empty_o(f_ae), .count_o(f_count), .overflow_o(f_ovf),
        .underflow_o(f_udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic [7:0] d, input logic q, input logic c);
        s_push = p; s_push_data = d; s_pop = q; s_clr = c;
        @(posedge clk); #1;
        s_push = 1'b0; s_pop = 1'b0; s_clr = 1'b0;
    endtask

    task automatic fcyc(input logic p, input logic [7:0] d, input logic q);
        f_push = p; f_push_data = d; f_pop = q;
        @(posedge clk); #1;
        f_push = 1'b0; f_pop = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #1 rst = 1'b0;
        #1;
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_full", 32'(s_full), 0);
        check("rst_ae", 32'(s_ae), 1);
        check("rst_af", 32'(s_af), 0);
        check("rst_ovf", 32'(s_ovf), 0);
        check("rst_udf", 32'(s_udf), 0);
        check("rst_data", 32'(s_pop_data), 0);
        check("rst_fwft_data", 32'(f_pop_data), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Basic push/pop with one-cycle read latency
        cyc(1'b1, 8'h12, 1'b0, 1'b0); check("b_cnt1", 32'(s_count), 1);
        cyc(1'b1, 8'hAC, 1'b0, 1'b0); check("b_cnt2", 32'(s_count), 2);
        cyc(1'b0, 8'h00, 1'b0, 1'b0); check("b_cnt2_idle", 32'(s_count), 2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("b_pop1_data", 32'(s_pop_data), 32'h12);
        check("b_pop1_cnt", 32'(s_count), 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("b_pop2_data", 32'(s_pop_data), 32'hAC);
        check("b_pop2_cnt", 32'(s_count), 0);
        check("b_empty", 32'(s_empty), 1);

        // Fill to full, thresholds, overflow, in-order drain
        for (int i = 0; i < 24; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            check("f_cnt", 32'(s_count), 32'(i + 1));
            check("f_af", 32'(s_af), (i + 1 >= 22) ? 32'd1 : 32'd0);
        end
        check("f_full", 32'(s_full), 1);
        check("f_ovf_pre", 32'(s_ovf), 0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check("f_ovf", 32'(s_ovf), 1);
        check("f_ovf_cnt", 32'(s_count), 24);
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("d_data", 32'(s_pop_data), 32'(i));
            check("d_cnt", 32'(s_count), 32'(23 - i));
            check("d_ae", 32'(s_ae), (23 - i <= 2) ? 32'd1 : 32'd0);
        end
        check("d_empty", 32'(s_empty), 1);
        check("d_ovf_sticky", 32'(s_ovf), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("d_ovf_clr", 32'(s_ovf), 0);

        // Full-rate push+pop across pointer wrap
        for (int i = 0; i < 24; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            cyc(1'b1, 8'(24 + k), 1'b1, 1'b0);
            check("w_data", 32'(s_pop_data), 32'(k));
            check("w_cnt", 32'(s_count), 24);
        end
        check("w_ovf", 32'(s_ovf), 0);
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("w_drain", 32'(s_pop_data), 32'(30 + i));
        end
        check("w_empty", 32'(s_empty), 1);

        // Underflow, push+pop on empty, clear and set-wins
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("u_udf", 32'(s_udf), 1);
        check("u_cnt0", 32'(s_count), 0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("u_pp_cnt", 32'(s_count), 1);
        check("u_pp_udf", 32'(s_udf), 1);
        check("u_pp_data", 32'(s_pop_data), 32'h35);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("u_clr", 32'(s_udf), 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("u_pop77", 32'(s_pop_data), 32'h77);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("u_setwins", 32'(s_udf), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("u_clr2", 32'(s_udf), 0);

        // Mid-cycle reset with 10 entries
        for (int i = 0; i < 11; i++) cyc(1'b1, 8'(64 + i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("r_pre_data", 32'(s_pop_data), 32'h40);
        check("r_pre_cnt", 32'(s_count), 10);
        #3 rst = 1'b0;
        #1;
        check("r_count", 32'(s_count), 0);
        check("r_empty", 32'(s_empty), 1);
        check("r_full", 32'(s_full), 0);
        check("r_ae", 32'(s_ae), 1);
        check("r_af", 32'(s_af), 0);
        check("r_ovf", 32'(s_ovf), 0);
        check("r_udf", 32'(s_udf), 0);
        check("r_data", 32'(s_pop_data), 0);
        @(posedge clk); #1 rst = 1'b1;
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        check("r_cnt2", 32'(s_count), 2);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("r_pop33", 32'(s_pop_data), 32'h33);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("r_pop44", 32'(s_pop_data), 32'h44);
        check("r_empty2", 32'(s_empty), 1);

        // FWFT instance
        check("fw_empty0", 32'(f_empty), 1);
        check("fw_data0", 32'(f_pop_data), 0);
        fcyc(1'b1, 8'h5A, 1'b0);
        check("fw_show", 32'(f_pop_data), 32'h5A);
        check("fw_nempty", 32'(f_empty), 0);
        check("fw_cnt1", 32'(f_count), 1);
        fcyc(1'b0, 8'h00, 1'b0);
        check("fw_hold", 32'(f_pop_data), 32'h5A);
        fcyc(1'b0, 8'h00, 1'b1);
        check("fw_empty1", 32'(f_empty), 1);
        check("fw_zero", 32'(f_pop_data), 0);
        fcyc(1'b1, 8'hA1, 1'b0);
        fcyc(1'b1, 8'hB2, 1'b0);
        check("fw_head", 32'(f_pop_data), 32'hA1);
        fcyc(1'b0, 8'h00, 1'b1);
        check("fw_next", 32'(f_pop_data), 32'hB2);
        fcyc(1'b0, 8'h00, 1'b1);
        check("fw_zero2", 32'(f_pop_data), 0);
        check("fw_udf", 32'(f_udf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
